// File: rtl/qpsk_diff_decoder.sv
// QPSK differential decoder: converts relative-code dibits into absolute-code dibits.
// Dibits are mapped to phases with a Gray code, and the phase difference is decoded.
// The block acquires a phase reference, detects gaps between symbols and counts
// decoded symbols.
module qpsk_diff_decoder #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resync,
    input  logic             din_valid,
    input  logic [1:0]       cd,
    output logic [1:0]       ab,
    output logic             ab_valid,
    output logic             locked,
    output logic [CNT_W-1:0] sym_cnt
);

    // The gap counter only has to reach TIMEOUT-1.
    localparam int unsigned GapW = $clog2(TIMEOUT);
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT - 1);

    typedef enum logic {StAcq, StRun} state_e;

    state_e           state_q, state_d;
    logic [1:0]       pref_q, pref_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [1:0]       ab_q, ab_d;
    logic             ab_valid_q, ab_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_in;

    // Gray dibit to phase: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gray_to_phase(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Phase to Gray dibit (inverse of the table above)
    function automatic logic [1:0] phase_to_gray(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Next-state logic: reference acquisition, decode, gap timeout and counting
    always_comb begin
        state_d    = state_q;
        pref_d     = pref_q;
        gap_d      = gap_q;
        ab_d       = ab_q;
        ab_valid_d = 1'b0;
        cnt_d      = cnt_q;
        phase_in   = gray_to_phase(cd);

        if (resync) begin
            // The colliding symbol is discarded; the next strobe becomes the reference.
            state_d = StAcq;
            gap_d   = '0;
        end else begin
            case (state_q)
                StAcq: begin
                    if (din_valid) begin
                        pref_d  = phase_in;
                        cnt_d   = '0;
                        gap_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    // A strobe takes priority over an expiring gap counter.
                    if (din_valid) begin
                        ab_d       = phase_to_gray(phase_in - pref_q);
                        ab_valid_d = 1'b1;
                        pref_d     = phase_in;
                        cnt_d      = cnt_q + 1'b1;
                        gap_d      = '0;
                    end else if (gap_q == GapLast) begin
                        state_d = StAcq;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = StAcq;
            endcase
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAcq;
            pref_q     <= 2'd0;
            gap_q      <= '0;
            ab_q       <= 2'b00;
            ab_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pref_q     <= pref_d;
            gap_q      <= gap_d;
            ab_q       <= ab_d;
            ab_valid_q <= ab_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ab       = ab_q;
    assign ab_valid = ab_valid_q;
    assign locked   = (state_q == StRun);
    assign sym_cnt  = cnt_q;

endmodule

// File: tb/tb_qpsk_diff_decoder.sv
// Self-checking bench for qpsk_diff_decoder, using a scoreboard of expected (ab, cycle) records.
module tb_qpsk_diff_decoder;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             resync = 1'b0;
    logic             din_valid = 1'b0;
    logic [1:0]       cd = 2'b00;
    logic [1:0]       ab;
    logic             ab_valid;
    logic             locked;
    logic [CNT_W-1:0] sym_cnt;

    typedef struct {
        logic [1:0] ab;
        int         cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    qpsk_diff_decoder #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .resync   (resync),
        .din_valid(din_valid),
        .cd       (cd),
        .ab       (ab),
        .ab_valid (ab_valid),
        .locked   (locked),
        .sym_cnt  (sym_cnt)
    );

    always #5 clk = ~clk;

    // Independent reference tables
    function automatic logic [1:0] ph(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] gr(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // One clock: drive inputs at the falling edge, record any output just after the rising edge
    task automatic tick(input logic dv, input logic [1:0] c, input logic rs);
        rec_t r;
        @(negedge clk);
        din_valid = dv;
        cd        = c;
        resync    = rs;
        @(posedge clk);
        cyc++;
        #1;
        if (ab_valid === 1'b1) begin
            r.ab  = ab;
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    endtask

    task automatic expect_ab(input logic [1:0] v);
        rec_t r;
        r.ab  = v;
        r.cyc = cyc + 1;
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (ab_valid !== 1'b0 || locked !== 1'b0 || sym_cnt !== '0 || ab !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: ab=%b ab_valid=%b locked=%b sym_cnt=%0d required 00 0 0 0",
                     ab, ab_valid, locked, sym_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_basic();
        logic [1:0] seq [5];
        rec_t e, o;
        seq = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) expect_ab(2'b01);
            tick(1'b1, seq[i], 1'b0);
            if (i == 0) begin
                checks++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_locked: locked=%b required 1", locked);
                end
            end
            repeat (3) tick(1'b0, 2'b00, 1'b0);
        end
        checks++;
        if (sym_cnt !== 4'd4) begin
            failures++;
            $display("FAIL basic_sym_cnt: got %0d required 4", sym_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL basic_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_half_turn();
        logic [1:0] seq [4];
        logic [1:0] res [3];
        rec_t e, o;
        seq = '{2'b00, 2'b11, 2'b00, 2'b00};
        res = '{2'b11, 2'b11, 2'b00};
        tick(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) expect_ab(res[i-1]);
            tick(1'b1, seq[i], 1'b0);
            tick(1'b0, 2'b00, 1'b0);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL half_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL half_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_phase_ambiguity();
        logic [1:0] seq [5];
        rec_t e, o;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        tick(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) expect_ab(2'b01);
            tick(1'b1, seq[i], 1'b0);
            tick(1'b0, 2'b00, 1'b0);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ambig_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL ambig_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_resync_collision();
        rec_t e, o;
        tick(1'b1, 2'b01, 1'b1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL resync_locked: locked=%b required 0", locked);
        end
        tick(1'b1, 2'b01, 1'b0);
        expect_ab(2'b01);
        tick(1'b1, 2'b11, 1'b0);
        tick(1'b0, 2'b00, 1'b0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL resync_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL resync_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Random back-to-back symbols; 17 decodes wrap the 4-bit counter to 1
    task automatic test_back_to_back(output logic [1:0] last_cd);
        logic [1:0] c, prev;
        rec_t e, o;
        tick(1'b0, 2'b00, 1'b1);
        prev = 2'($urandom_range(0, 3));
        tick(1'b1, prev, 1'b0);
        for (int i = 0; i < 17; i++) begin
            c = 2'($urandom_range(0, 3));
            expect_ab(gr(ph(c) - ph(prev)));
            tick(1'b1, c, 1'b0);
            prev = c;
        end
        tick(1'b0, 2'b00, 1'b0);
        last_cd = prev;
        checks++;
        if (sym_cnt !== 4'd1) begin
            failures++;
            $display("FAIL b2b_sym_cnt_wrap: got %0d required 1", sym_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL b2b_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // A strobe arriving on the very cycle the gap counter expires keeps the lock
    task automatic test_timeout_boundary(input logic [1:0] prev);
        rec_t e, o;
        // One idle tick already followed the last strobe in the previous test.
        repeat (TIMEOUT - 2) tick(1'b0, 2'b00, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL boundary_pre_locked: locked=%b required 1", locked);
        end
        expect_ab(gr(ph(2'b10) - ph(prev)));
        tick(1'b1, 2'b10, 1'b0);
        checks++;
        if (locked !== 1'b1 || sym_cnt !== 4'd2) begin
            failures++;
            $display("FAIL boundary_lock: locked=%b sym_cnt=%0d required 1 2", locked, sym_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL boundary_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL boundary_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_timeout();
        rec_t e, o;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick(1'b0, 2'b00, 1'b0);
            checks++;
            if (locked !== ((k == int'(TIMEOUT)) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL timeout_locked: cycle %0d after strobe locked=%b required %b",
                         k, locked, (k == int'(TIMEOUT)) ? 1'b0 : 1'b1);
            end
        end
        checks++;
        if (sym_cnt !== 4'd2) begin
            failures++;
            $display("FAIL timeout_sym_cnt_hold: got %0d required 2", sym_cnt);
        end
        tick(1'b1, 2'b11, 1'b0);
        expect_ab(2'b01);
        tick(1'b1, 2'b10, 1'b0);
        checks++;
        if (sym_cnt !== 4'd1) begin
            failures++;
            $display("FAIL timeout_sym_cnt_restart: got %0d required 1", sym_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL timeout_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL timeout_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset();
        rec_t e, o;
        tick(1'b1, 2'b00, 1'b0);
        tick(1'b1, 2'b01, 1'b0);
        checks++;
        if (ab_valid !== 1'b1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: ab_valid=%b locked=%b required 1 1", ab_valid, locked);
        end
        // Mid-cycle reset, well before the next rising edge
        #2;
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        checks++;
        if (ab_valid !== 1'b0 || locked !== 1'b0 || sym_cnt !== '0) begin
            failures++;
            $display("FAIL areset_immediate: ab_valid=%b locked=%b sym_cnt=%0d required 0 0 0",
                     ab_valid, locked, sym_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        tick(1'b1, 2'b01, 1'b0);
        checks++;
        if (ab_valid !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL areset_reacq: ab_valid=%b locked=%b required 0 1", ab_valid, locked);
        end
        expect_ab(2'b11);
        tick(1'b1, 2'b10, 1'b0);
        tick(1'b0, 2'b00, 1'b0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL areset_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ab !== e.ab || o.cyc != e.cyc) begin
                failures++;
                $display("FAIL areset_ab: got %b@%0d required %b@%0d", o.ab, o.cyc, e.ab, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        logic [1:0] last_cd;
        test_reset();
        test_basic();
        test_half_turn();
        test_phase_ambiguity();
        test_resync_collision();
        test_back_to_back(last_cd);
        test_timeout_boundary(last_cd);
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
